// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding, register-index width and NOP control fields (package pipe_ctrl_pkg)
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } ctrl_state_e;
  localparam int REG_IDX_W = 5;
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_fields_t;
  localparam ctrl_fields_t NOP_CTRL = '{reg_write: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0};
  function automatic logic load_use(logic mem_read, logic [REG_IDX_W-1:0] rd, logic [REG_IDX_W-1:0] rs,
                                    logic [REG_IDX_W-1:0] rt);
    return mem_read && rd != '0 && (rd == rs || rd == rt);
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [pipe_ctrl_pkg::REG_IDX_W-1:0] id_rs, id_rt, ex_rd;
  logic ex_mem_read, ex_branch_taken, id_jump, mem_req, mem_ready;
  logic pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic ifid_flush, idex_flush, memwb_bubble, mem_fault;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] load_stall_cnt, mem_wait_cnt;
  modport master(
    output id_rs, id_rt, ex_rd, ex_mem_read, ex_branch_taken, id_jump, mem_req, mem_ready,
    input pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, memwb_bubble, mem_fault,
    input ctrl_state, load_stall_cnt, mem_wait_cnt
  );
  modport slave(
    input id_rs, id_rt, ex_rd, ex_mem_read, ex_branch_taken, id_jump, mem_req, mem_ready,
    output pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, memwb_bubble, mem_fault,
    output ctrl_state, load_stall_cnt, mem_wait_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/branch/jump hazard steering, memory-wait freeze with timeout fault.
// Performance counters exist only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);
  ctrl_state_e state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic lu, freeze, steer, br, stall_lu, jmp;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  always_comb begin
    lu       = load_use(hz.ex_mem_read, hz.ex_rd, hz.id_rs, hz.id_rt);
    freeze   = !reset && (state == FAULT || !hz.mem_ready && (state == MEM_WAIT || hz.mem_req));
    steer    = !reset && !freeze;
    br       = steer && hz.ex_branch_taken;
    stall_lu = steer && !hz.ex_branch_taken && lu;
    jmp      = steer && !hz.ex_branch_taken && !lu && hz.id_jump;
    state_nx = state == RUN ? (hz.mem_req && !hz.mem_ready ? MEM_WAIT : RUN)
             : state == MEM_WAIT ? (hz.mem_ready ? RUN : wait_cnt == LAST ? FAULT : MEM_WAIT)
             : FAULT;
    wait_nx  = state == MEM_WAIT ? wait_cnt + 1'b1 : '0;
  end
  assign hz.pc_hold      = freeze || stall_lu;
  assign hz.ifid_hold    = freeze || stall_lu;
  assign hz.idex_hold    = freeze;
  assign hz.exmem_hold   = freeze;
  assign hz.ifid_flush   = br || jmp;
  assign hz.idex_flush   = br || stall_lu;
  assign hz.memwb_bubble = freeze;
  assign hz.mem_fault    = state == FAULT;
  assign hz.ctrl_state   = state;
`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk(clk), .reset(reset), .en(stall_lu), .cnt(hz.load_stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_mw_cnt (
    .clk(clk), .reset(reset), .en(state == MEM_WAIT), .cnt(hz.mem_wait_cnt)
  );
`else
  assign hz.load_stall_cnt = '0;
  assign hz.mem_wait_cnt   = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table vectors, hand-built memory sequences and random traffic against a rule-level model
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct packed {
    logic [4:0] rs, rt, rd;
    logic mr, br, jmp, req, rdy;
  } in_t;
  typedef struct {
    in_t in;
    logic [7:0] ctrl;
  } vec_t;
  logic clk, reset;
  int n_vec, n_bad;
  int m_mode, m_waits, m_lu, m_mw;
  logic [7:0] act_ctrl;
  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .hz(hz.slave));
  assign act_ctrl = {hz.pc_hold, hz.ifid_hold, hz.idex_hold, hz.exmem_hold,
                     hz.ifid_flush, hz.idex_flush, hz.memwb_bubble, hz.mem_fault};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit m_loaduse(in_t v);
    return v.mr && v.rd != 0 && (v.rd == v.rs || v.rd == v.rt);
  endfunction
  // Memory freeze: stuck in fault, or data memory not ready while an access is pending
  function automatic bit m_frozen(in_t v);
    return m_mode == 2 || (!v.rdy && (m_mode == 1 || v.req));
  endfunction
  function automatic logic [7:0] m_ctrl(in_t v);
    if (m_frozen(v)) return 8'b1111_0010 | {7'd0, m_mode == 2};
    if (v.br) return 8'b0000_1100;
    if (m_loaduse(v)) return 8'b1100_0100;
    if (v.jmp) return 8'b0000_1000;
    return 8'd0;
  endfunction
  task automatic advance(in_t v);
    if (!m_frozen(v) && !v.br && m_loaduse(v) && m_lu < CMAX) m_lu++;
    if (m_mode == 1 && m_mw < CMAX) m_mw++;
    if (m_mode == 0) begin
      if (v.req && !v.rdy) begin
        m_mode  = 1;
        m_waits = 0;
      end
    end else if (m_mode == 1) begin
      if (v.rdy) m_mode = 0;
      else if (m_waits == TO - 1) m_mode = 2;
      else m_waits++;
    end
  endtask
  task automatic drive(in_t v);
    hz.id_rs = v.rs;
    hz.id_rt = v.rt;
    hz.ex_rd = v.rd;
    hz.ex_mem_read = v.mr;
    hz.ex_branch_taken = v.br;
    hz.id_jump = v.jmp;
    hz.mem_req = v.req;
    hz.mem_ready = v.rdy;
  endtask
  task automatic step(in_t v);
    drive(v);
    #2;
    cmp("ctrl", act_ctrl, m_ctrl(v));
    cmp("state", hz.ctrl_state, m_mode);
    cmp("load_stall_cnt", hz.load_stall_cnt, PERF ? m_lu : 0);
    cmp("mem_wait_cnt", hz.mem_wait_cnt, PERF ? m_mw : 0);
    @(posedge clk);
    advance(v);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_mode = 0;
    m_waits = 0;
    m_lu = 0;
    m_mw = 0;
    cmp("reset_ctrl", act_ctrl, 8'd0);
    cmp("reset_state", hz.ctrl_state, 0);
    cmp("reset_lu_cnt", hz.load_stall_cnt, 0);
    cmp("reset_mw_cnt", hz.mem_wait_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  function automatic in_t mk(int rs, int rt, int rd, bit mr, bit br, bit jmp, bit req, bit rdy);
    in_t v;
    v.rs = 5'(rs);
    v.rt = 5'(rt);
    v.rd = 5'(rd);
    v.mr = mr;
    v.br = br;
    v.jmp = jmp;
    v.req = req;
    v.rdy = rdy;
    return v;
  endfunction
  initial begin
    vec_t tbl[$];
    in_t idle, v;
    int mw0, lu0;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    #1;
    do_reset();
    tbl.push_back('{mk(8, 3, 8, 1, 0, 0, 0, 0), 8'b1100_0100});
    tbl.push_back('{mk(0, 0, 0, 1, 0, 0, 0, 0), 8'b0000_0000});
    tbl.push_back('{mk(2, 9, 9, 1, 0, 0, 0, 0), 8'b1100_0100});
    tbl.push_back('{mk(8, 8, 8, 0, 0, 0, 0, 0), 8'b0000_0000});
    tbl.push_back('{mk(8, 3, 8, 1, 1, 0, 0, 0), 8'b0000_1100});
    tbl.push_back('{mk(8, 3, 8, 1, 0, 1, 0, 0), 8'b1100_0100});
    tbl.push_back('{mk(1, 2, 3, 1, 0, 1, 0, 0), 8'b0000_1000});
    tbl.push_back('{mk(1, 2, 3, 0, 0, 0, 1, 1), 8'b0000_0000});
    tbl.push_back('{mk(1, 2, 3, 0, 1, 0, 1, 1), 8'b0000_1100});
    tbl.push_back('{mk(4, 4, 4, 1, 0, 0, 1, 1), 8'b1100_0100});
    foreach (tbl[i]) begin
      drive(tbl[i].in);
      #1;
      cmp($sformatf("tbl%0d", i), act_ctrl, tbl[i].ctrl);
      step(tbl[i].in);
    end
    cmp("tbl_lu_total", hz.load_stall_cnt, PERF ? 4 : 0);
    // Memory ready on the 3rd cycle after the request
    mw0 = hz.mem_wait_cnt;
    lu0 = hz.load_stall_cnt;
    for (int i = 0; i < 3; i++) begin
      v = mk(8, 0, 8, 1, 0, 0, 1, 0);
      drive(v);
      #1;
      cmp("memwait_freeze", act_ctrl, 8'b1111_0010);
      step(v);
    end
    step(mk(0, 0, 0, 0, 0, 0, 1, 1));
    cmp("memwait_back_run", hz.ctrl_state, 0);
    cmp("memwait_cnt3", hz.mem_wait_cnt - mw0, PERF ? 3 : 0);
    cmp("memwait_no_lu", hz.load_stall_cnt - lu0, 0);
    // Single-cycle access
    v = mk(0, 0, 0, 0, 0, 0, 1, 1);
    step(v);
    cmp("single_cycle_state", hz.ctrl_state, 0);
    // Timeout into fault
    do_reset();
    for (int i = 0; i < 1 + TO; i++) step(mk(0, 0, 0, 0, 0, 0, 1, 0));
    cmp("fault_flag", hz.mem_fault, 1);
    cmp("fault_state", hz.ctrl_state, 2);
    cmp("fault_mw_cnt", hz.mem_wait_cnt, PERF ? TO : 0);
    step(mk(5, 5, 5, 1, 1, 1, 1, 1));
    step(idle);
    do_reset();
    cmp("fault_cleared", hz.mem_fault, 0);
    // Reset during the second cycle of a memory wait
    step(mk(0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 1, 0));
    cmp("midwait_state", hz.ctrl_state, 1);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0));
    #1;
    do_reset();
    drive(idle);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1),
               $urandom_range(0, 2) != 0);
        step(v);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
